// File: rtl/vm_pkg.sv
// Shared FSM type, coin denominations and burst sizing for the vm_stock controller.
package vm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_OUT  = 2'd2
    } vm_state_e;

    localparam int unsigned DENOM_50 = 50;
    localparam int unsigned DENOM_20 = 20;
    localparam int unsigned DENOM_10 = 10;
    localparam int unsigned DENOM_5  = 5;
    localparam int unsigned DENOM_1  = 1;
    localparam int NUM_DENOM    = 5;
    localparam int BURST_PREFIX = 6;

    function automatic logic is_denom(input logic [31:0] v);
        return (v == DENOM_50) || (v == DENOM_20) || (v == DENOM_10) ||
               (v == DENOM_5)  || (v == DENOM_1);
    endfunction

endpackage

// File: rtl/vm_change.sv
// Greedy change decomposer: splits an amount into 50/20/10/5/1 counts.
// Count for 50 sits in the lowest CONS_W slice, 1 in the highest.
module vm_change
    import vm_pkg::*;
#(
    parameter int MON_W  = 9,
    parameter int CONS_W = 4
) (
    input  logic [MON_W-1:0]            change_in,
    output logic [NUM_DENOM*CONS_W-1:0] counts
);

    localparam logic [MON_W-1:0] D50 = MON_W'(DENOM_50);
    localparam logic [MON_W-1:0] D20 = MON_W'(DENOM_20);
    localparam logic [MON_W-1:0] D10 = MON_W'(DENOM_10);
    localparam logic [MON_W-1:0] D5  = MON_W'(DENOM_5);

    logic [MON_W-1:0]  r50, r20, r10;
    logic [CONS_W-1:0] n50, n20, n10, n5, n1;

    always_comb begin
        n50 = CONS_W'(change_in / D50);
        r50 = change_in % D50;
        n20 = CONS_W'(r50 / D20);
        r20 = r50 % D20;
        n10 = CONS_W'(r20 / D10);
        r10 = r20 % D10;
        n5  = CONS_W'(r10 / D5);
        n1  = CONS_W'(r10 % D5);
        counts = {n1, n5, n10, n20, n50};
    end

endmodule

// File: rtl/vm_stock.sv
// Parametrised vending controller: price/stock load, coin credit, buy/return bursts.
// Optional per-item stock tracking is enabled by defining VM_STOCK_EN.
//
//   state   | meaning
//   IDLE    | accept load strobe, coins, or a buy/return request
//   LOAD    | write price (and stock) for items 2..ITEM_CNT, one per cycle
//   OUT     | stream change counts and sold counts for BURST_LEN beats
module vm_stock
    import vm_pkg::*;
#(
    parameter int ITEM_CNT = 6,
    parameter int PRICE_W  = 5,
    parameter int COIN_W   = 6,
    parameter int MON_W    = 9,
    parameter int SELL_W   = 6,
    parameter int STOCK_W  = 2,
    parameter int CONS_W   = 4,
    localparam int IDX_W   = $clog2(ITEM_CNT + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_item_valid,
    input  logic [PRICE_W-1:0] in_item_price,
    input  logic [STOCK_W-1:0] in_item_num,
    input  logic               in_coin_valid,
    input  logic [COIN_W-1:0]  in_coin,
    input  logic               in_rtn_coin,
    input  logic [IDX_W-1:0]   in_buy_item,
    output logic [MON_W-1:0]   out_monitor,
    output logic               out_valid,
    output logic [CONS_W-1:0]  out_consumer,
    output logic [SELL_W-1:0]  out_sell_num
);

    localparam int BURST_LEN = (ITEM_CNT > BURST_PREFIX) ? ITEM_CNT : BURST_PREFIX;
    localparam int CNT_W     = $clog2(BURST_LEN + 1);
    localparam int SEL_W     = (ITEM_CNT > 1) ? $clog2(ITEM_CNT) : 1;

    vm_state_e                   state_q, state_d;
    logic [CNT_W-1:0]            rem_q, rem_d;
    logic [PRICE_W-1:0]          price_q [ITEM_CNT];
    logic [PRICE_W-1:0]          price_d [ITEM_CNT];
    logic [SELL_W-1:0]           sold_q  [ITEM_CNT];
    logic [SELL_W-1:0]           sold_d  [ITEM_CNT];
    logic [MON_W-1:0]            credit_q, credit_d;
    logic [NUM_DENOM*CONS_W-1:0] cnt_q, cnt_d, change_cnt;
    logic                        valid_q, valid_d;
    logic [CONS_W-1:0]           cons_q, cons_d;
    logic [SELL_W-1:0]           sell_q, sell_d;

    logic [MON_W:0]              coin_sum;
    logic [MON_W-1:0]            change_amt;
    logic [SEL_W-1:0]            buy_sel, load_sel;
    logic [CNT_W-1:0]            next_beat;
    logic                        buy_req, buy_ok, in_stock;

`ifdef VM_STOCK_EN
    logic [STOCK_W-1:0]          stock_q [ITEM_CNT];
    logic [STOCK_W-1:0]          stock_d [ITEM_CNT];
    assign in_stock = (stock_q[buy_sel] != '0);
`else
    logic unused_num;
    assign unused_num = ^in_item_num;
    assign in_stock   = 1'b1;
`endif

    // One extra sum bit flags overflow so a too-large coin can be rejected.
    assign coin_sum   = {1'b0, credit_q} + (MON_W+1)'(in_coin);
    assign buy_req    = (in_buy_item != '0);
    assign buy_sel    = SEL_W'(in_buy_item - 1'b1);
    assign buy_ok     = buy_req && (in_buy_item <= IDX_W'(ITEM_CNT)) &&
                        (credit_q >= MON_W'(price_q[buy_sel])) && in_stock;
    assign change_amt = in_rtn_coin ? credit_q : credit_q - MON_W'(price_q[buy_sel]);
    assign load_sel   = SEL_W'(CNT_W'(ITEM_CNT) - rem_q);
    assign next_beat  = CNT_W'(BURST_LEN) - rem_q;

    vm_change #(.MON_W(MON_W), .CONS_W(CONS_W)) u_change (
        .change_in (change_amt),
        .counts    (change_cnt)
    );

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        price_d  = price_q;
        sold_d   = sold_q;
        credit_d = credit_q;
        cnt_d    = cnt_q;
`ifdef VM_STOCK_EN
        stock_d  = stock_q;
`endif
        valid_d  = 1'b0;
        cons_d   = '0;
        sell_d   = '0;
        unique case (state_q)
            ST_IDLE: begin
                // The strobe cycle itself carries item 1; LOAD covers the rest.
                if (in_item_valid) begin
                    price_d[0] = in_item_price;
`ifdef VM_STOCK_EN
                    stock_d[0] = in_item_num;
`endif
                    for (int i = 0; i < ITEM_CNT; i++) sold_d[i] = '0;
                    rem_d = CNT_W'(ITEM_CNT - 1);
                    if (ITEM_CNT > 1) state_d = ST_LOAD;
                end else if (in_coin_valid) begin
                    if (is_denom(32'(in_coin)) && !coin_sum[MON_W])
                        credit_d = coin_sum[MON_W-1:0];
                end else if (in_rtn_coin || buy_req) begin
                    state_d = ST_OUT;
                    rem_d   = CNT_W'(BURST_LEN - 1);
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    if (in_rtn_coin || buy_ok) begin
                        cnt_d    = change_cnt;
                        credit_d = '0;
                    end
                    if (!in_rtn_coin && buy_ok) begin
                        if (sold_q[buy_sel] != '1) sold_d[buy_sel] = sold_q[buy_sel] + 1'b1;
`ifdef VM_STOCK_EN
                        stock_d[buy_sel] = stock_q[buy_sel] - 1'b1;
`endif
                        cons_d = CONS_W'(in_buy_item);
                    end
                    sell_d = sold_d[0];
                end
            end
            ST_LOAD: begin
                price_d[load_sel] = in_item_price;
`ifdef VM_STOCK_EN
                stock_d[load_sel] = in_item_num;
`endif
                rem_d = rem_q - 1'b1;
                if (rem_q == CNT_W'(1)) state_d = ST_IDLE;
            end
            ST_OUT: begin
                if (rem_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    valid_d = 1'b1;
                    rem_d   = rem_q - 1'b1;
                    for (int i = 0; i < NUM_DENOM; i++)
                        if (next_beat == CNT_W'(i + 1)) cons_d = cnt_q[i*CONS_W +: CONS_W];
                    for (int i = 0; i < ITEM_CNT; i++)
                        if (next_beat == CNT_W'(i)) sell_d = sold_q[i];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            price_q  <= '{default: '0};
            sold_q   <= '{default: '0};
`ifdef VM_STOCK_EN
            stock_q  <= '{default: '0};
`endif
            credit_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            cons_q   <= '0;
            sell_q   <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            price_q  <= price_d;
            sold_q   <= sold_d;
`ifdef VM_STOCK_EN
            stock_q  <= stock_d;
`endif
            credit_q <= credit_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            cons_q   <= cons_d;
            sell_q   <= sell_d;
        end
    end

    assign out_monitor  = credit_q;
    assign out_valid    = valid_q;
    assign out_consumer = cons_q;
    assign out_sell_num = sell_q;

endmodule

// File: tb/tb_vm_stock.sv
// Directed bench for vm_stock at default parameters; expectations adapt to VM_STOCK_EN.
module tb_vm_stock;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_item_valid = 1'b0;
    logic [4:0] in_item_price = '0;
    logic [1:0] in_item_num = '0;
    logic       in_coin_valid = 1'b0;
    logic [5:0] in_coin = '0;
    logic       in_rtn_coin = 1'b0;
    logic [2:0] in_buy_item = '0;
    logic [8:0] out_monitor;
    logic       out_valid;
    logic [3:0] out_consumer;
    logic [5:0] out_sell_num;

    int n_vec = 0;
    int n_err = 0;

    logic [4:0] prices [6] = '{5'd5, 5'd10, 5'd15, 5'd20, 5'd25, 5'd30};
    logic [1:0] stocks [6] = '{2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};

    always #5 clk = ~clk;

    vm_stock dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_item_valid (in_item_valid),
        .in_item_price (in_item_price),
        .in_item_num   (in_item_num),
        .in_coin_valid (in_coin_valid),
        .in_coin       (in_coin),
        .in_rtn_coin   (in_rtn_coin),
        .in_buy_item   (in_buy_item),
        .out_monitor   (out_monitor),
        .out_valid     (out_valid),
        .out_consumer  (out_consumer),
        .out_sell_num  (out_sell_num)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input int v);
        in_coin_valid = 1'b1;
        in_coin       = 6'(v);
        tick();
        in_coin_valid = 1'b0;
        in_coin       = '0;
    endtask

    // ec/es hold six 8-bit beats, beat 0 in the top byte.
    task automatic burst(input string tag, input int buy, input bit rtn, input int mid_coin,
                         input logic [47:0] ec, input logic [47:0] es, input int emon);
        in_buy_item = 3'(buy);
        in_rtn_coin = rtn;
        tick();
        in_buy_item = '0;
        in_rtn_coin = 1'b0;
        chk({tag, " mon"}, 32'(out_monitor), emon);
        for (int b = 0; b < 6; b++) begin
            chk($sformatf("%s valid b%0d", tag, b), 32'(out_valid), 1);
            chk($sformatf("%s cons b%0d", tag, b), 32'(out_consumer), 32'(ec[8*(5-b) +: 8]));
            chk($sformatf("%s sell b%0d", tag, b), 32'(out_sell_num), 32'(es[8*(5-b) +: 8]));
            if (b == 2 && mid_coin != 0) begin
                in_coin_valid = 1'b1;
                in_coin       = 6'(mid_coin);
            end
            tick();
            in_coin_valid = 1'b0;
            in_coin       = '0;
        end
        chk({tag, " valid end"}, 32'(out_valid), 0);
        chk({tag, " cons end"}, 32'(out_consumer), 0);
        chk({tag, " mon end"}, 32'(out_monitor), emon);
    endtask

    initial begin
        repeat (2) tick();
        chk("rst mon", 32'(out_monitor), 0);
        chk("rst valid", 32'(out_valid), 0);
        chk("rst cons", 32'(out_consumer), 0);
        chk("rst sell", 32'(out_sell_num), 0);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 6; k++) begin
            in_item_valid = 1'b1;
            in_item_price = prices[k];
            in_item_num   = stocks[k];
            tick();
        end
        in_item_valid = 1'b0;
        in_item_price = '0;
        in_item_num   = '0;

        coin(50); chk("coin50", 32'(out_monitor), 50);
        coin(20); chk("coin20", 32'(out_monitor), 70);
        coin(5);  chk("coin5", 32'(out_monitor), 75);
        burst("buy3", 3, 0, 0, {8'd3, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0},
              {8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0}, 0);

        coin(10); chk("coin10", 32'(out_monitor), 10);
        coin(7);  chk("coin7 ignored", 32'(out_monitor), 10);
        burst("buy6 fail", 6, 0, 0, 48'd0, {8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0}, 10);

        for (int i = 0; i < 4; i++) coin(1);
        chk("coin1x4", 32'(out_monitor), 14);
        burst("rtn14", 0, 1, 0, {8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd4},
              {8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0}, 0);

        coin(5);
        burst("buy1a", 1, 0, 0, {8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
              {8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0}, 0);
        coin(5);
`ifdef VM_STOCK_EN
        burst("buy1b", 1, 0, 0, 48'd0, {8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0}, 5);
        burst("rtn5", 0, 1, 0, {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0},
              {8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0}, 0);
`else
        burst("buy1b", 1, 0, 0, {8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
              {8'd2, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0}, 0);
        burst("rtn0", 0, 1, 0, 48'd0, {8'd2, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0}, 0);
`endif

        for (int i = 0; i < 10; i++) coin(50);
        chk("coin to 500", 32'(out_monitor), 500);
        coin(50); chk("coin50 over", 32'(out_monitor), 500);
        coin(10); chk("coin to 510", 32'(out_monitor), 510);
        coin(1);  chk("coin to 511", 32'(out_monitor), 511);
        coin(1);  chk("coin1 over", 32'(out_monitor), 511);
`ifdef VM_STOCK_EN
        burst("rtn+buy2", 2, 1, 50, {8'd0, 8'd10, 8'd0, 8'd1, 8'd0, 8'd1},
              {8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0}, 0);
`else
        burst("rtn+buy2", 2, 1, 50, {8'd0, 8'd10, 8'd0, 8'd1, 8'd0, 8'd1},
              {8'd2, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0}, 0);
`endif

        coin(20); chk("coin20 pre-rst", 32'(out_monitor), 20);
        in_buy_item = 3'd2;
        tick();
        in_buy_item = '0;
        chk("mid valid b0", 32'(out_valid), 1);
        chk("mid cons b0", 32'(out_consumer), 2);
        tick();
        chk("mid sell b1", 32'(out_sell_num), 1);
        rst_n = 1'b0;
        tick();
        chk("mid rst valid", 32'(out_valid), 0);
        chk("mid rst cons", 32'(out_consumer), 0);
        chk("mid rst sell", 32'(out_sell_num), 0);
        chk("mid rst mon", 32'(out_monitor), 0);
        rst_n = 1'b1;
        tick();
        coin(5); chk("post rst coin", 32'(out_monitor), 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
